// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline definitions: stall encoding, zero constants and the
// per-lane write-back bundle.
package pipe_pkg;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  localparam int PKG_DATA_W = 32;
  localparam int PKG_ADDR_W = 5;

  localparam logic [PKG_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [PKG_ADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [PKG_ADDR_W-1:0] waddr;
    logic [PKG_DATA_W-1:0] wdata;
    logic                  wen_hilo;
    logic [PKG_DATA_W-1:0] hi;
    logic [PKG_DATA_W-1:0] lo;
  } wb_bundle_t;

  // MEM held while WB drains: inject a bubble so the held op is not retired twice.
  function automatic logic is_bubble(input logic flush, input logic [1:0] stall);
    return flush | ((stall[0] == STOP) & (stall[1] == NOT_STOP));
  endfunction

endpackage

// File: rtl/wb_collision_resolve.sv
// Combinational same-cycle write collision resolver: for equal GPR addresses
// and for HI/LO, the youngest (highest-index) enabled lane keeps its enable.
module wb_collision_resolve #(
  parameter int LANES  = 2,
  parameter int ADDR_W = 5
) (
  input  logic [LANES-1:0]             wen_i,
  input  logic [LANES-1:0]             hilo_i,
  input  logic [LANES-1:0][ADDR_W-1:0] waddr_i,
  output logic [LANES-1:0]             wen_o,
  output logic [LANES-1:0]             hilo_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic gpr_kill;
    logic hilo_kill;

    always_comb begin
      gpr_kill  = 1'b0;
      hilo_kill = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (wen_i[j] && (waddr_i[j] == waddr_i[i])) gpr_kill = 1'b1;
        if (hilo_i[j]) hilo_kill = 1'b1;
      end
    end

    assign wen_o[i]  = wen_i[i] & ~gpr_kill;
    assign hilo_o[i] = hilo_i[i] & ~hilo_kill;
  end

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM->WB pipeline register with flush, 2-bit stall and collision
// resolution. Define MEM_WB_PERF_CNT_EN to add STALL_CNT/BUBBLE_CNT counters.
module mem_wb_multi
  import pipe_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [1:0]              STALL,
  input  logic                    FLUSH,
  input  logic [LANES-1:0]        MEM_VALID,
  input  logic [LANES*DATA_W-1:0] MEM_WDATA,
  input  logic [LANES*ADDR_W-1:0] MEM_WADDR,
  input  logic [LANES-1:0]        MEM_WEN,
  input  logic [LANES*DATA_W-1:0] MEM_HI,
  input  logic [LANES*DATA_W-1:0] MEM_LO,
  input  logic [LANES-1:0]        MEM_WEN_HILO,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [CNT_W-1:0]        STALL_CNT,
  output logic [CNT_W-1:0]        BUBBLE_CNT,
`endif
  output logic [LANES-1:0]        WB_VALID,
  output logic [LANES-1:0]        WB_WEN,
  output logic [LANES-1:0]        WB_WEN_HILO,
  output logic [LANES*DATA_W-1:0] WB_WDATA,
  output logic [LANES*ADDR_W-1:0] WB_WADDR,
  output logic [LANES*DATA_W-1:0] WB_HI,
  output logic [LANES*DATA_W-1:0] WB_LO
);

  if (LANES < 1 || LANES > 4 || CNT_W < 1) begin : g_param_chk
    $error("mem_wb_multi: LANES must be 1..4 and CNT_W >= 1");
  end

  logic [LANES-1:0][DATA_W-1:0] mem_wdata, mem_hi, mem_lo;
  logic [LANES-1:0][ADDR_W-1:0] mem_waddr;

  assign mem_wdata = MEM_WDATA;
  assign mem_hi    = MEM_HI;
  assign mem_lo    = MEM_LO;
  assign mem_waddr = MEM_WADDR;

  // Writes to $0 and writes from invalid lanes are dropped before collision checks.
  logic [LANES-1:0] qual_wen, qual_hilo, res_wen, res_hilo;

  for (genvar i = 0; i < LANES; i++) begin : g_qual
    assign qual_wen[i]  = MEM_WEN[i] & MEM_VALID[i] & (mem_waddr[i] != ADDR_W'(ZERO_ADDR));
    assign qual_hilo[i] = MEM_WEN_HILO[i] & MEM_VALID[i];
  end

  wb_collision_resolve #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_resolve (
    .wen_i   (qual_wen),
    .hilo_i  (qual_hilo),
    .waddr_i (mem_waddr),
    .wen_o   (res_wen),
    .hilo_o  (res_hilo)
  );

  logic bubble, capture;
  assign bubble  = is_bubble(FLUSH, STALL);
  assign capture = (STALL[0] == NOT_STOP);

  logic [LANES-1:0]             valid_q, valid_d;
  logic [LANES-1:0]             wen_q, wen_d;
  logic [LANES-1:0]             hilo_q, hilo_d;
  logic [LANES-1:0][ADDR_W-1:0] waddr_q, waddr_d;
  logic [LANES-1:0][DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0][DATA_W-1:0] hi_q, hi_d;
  logic [LANES-1:0][DATA_W-1:0] lo_q, lo_d;

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    hilo_d  = hilo_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (bubble) begin
      valid_d = '0;
      wen_d   = '0;
      hilo_d  = '0;
      waddr_d = '0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
    end else if (capture) begin
      valid_d = MEM_VALID;
      wen_d   = res_wen;
      hilo_d  = res_hilo;
      waddr_d = mem_waddr;
      wdata_d = mem_wdata;
      hi_d    = mem_hi;
      lo_d    = mem_lo;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= '0;
      wen_q   <= '0;
      hilo_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      hilo_q  <= hilo_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign WB_VALID    = valid_q;
  assign WB_WEN      = wen_q;
  assign WB_WEN_HILO = hilo_q;
  assign WB_WADDR    = waddr_q;
  assign WB_WDATA    = wdata_q;
  assign WB_HI       = hi_q;
  assign WB_LO       = lo_q;

`ifdef MEM_WB_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; only reset clears them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((STALL[1] == STOP) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bubble && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign STALL_CNT  = stall_cnt_q;
  assign BUBBLE_CNT = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_multi.sv
// Directed plus randomized bench for mem_wb_multi against a per-lane
// behavioural model of the write-back rules.
module tb_mem_wb_multi;
  import pipe_pkg::*;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;
  logic [1:0] STALL;
  logic FLUSH;
  logic [LANES-1:0] MEM_VALID, MEM_WEN, MEM_WEN_HILO;
  logic [LANES-1:0][DATA_W-1:0] MEM_WDATA, MEM_HI, MEM_LO;
  logic [LANES-1:0][ADDR_W-1:0] MEM_WADDR;
  logic [LANES-1:0] WB_VALID, WB_WEN, WB_WEN_HILO;
  logic [LANES-1:0][DATA_W-1:0] WB_WDATA, WB_HI, WB_LO;
  logic [LANES-1:0][ADDR_W-1:0] WB_WADDR;
`ifdef MEM_WB_PERF_CNT_EN
  logic [CNT_W-1:0] STALL_CNT, BUBBLE_CNT;
`endif

  int checks = 0;
  int failures = 0;

  wb_bundle_t exp_q [LANES];
  int exp_stall = 0;
  int exp_bubble = 0;

  always #5 CLK = ~CLK;

  mem_wb_multi #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
    .MEM_VALID(MEM_VALID), .MEM_WDATA(MEM_WDATA), .MEM_WADDR(MEM_WADDR),
    .MEM_WEN(MEM_WEN), .MEM_HI(MEM_HI), .MEM_LO(MEM_LO), .MEM_WEN_HILO(MEM_WEN_HILO),
`ifdef MEM_WB_PERF_CNT_EN
    .STALL_CNT(STALL_CNT), .BUBBLE_CNT(BUBBLE_CNT),
`endif
    .WB_VALID(WB_VALID), .WB_WEN(WB_WEN), .WB_WEN_HILO(WB_WEN_HILO),
    .WB_WDATA(WB_WDATA), .WB_WADDR(WB_WADDR), .WB_HI(WB_HI), .WB_LO(WB_LO)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (exp_q[i]) exp_q[i] = '0;
    exp_stall  = 0;
    exp_bubble = 0;
  endtask

  // Applies the write-back rules to the inputs present at the coming edge.
  task automatic model_edge();
    wb_bundle_t nx [LANES];
    bit seen [32];
    bit hilo_taken;
    nx = exp_q;
    if (FLUSH || (STALL == 2'b01)) begin
      foreach (nx[i]) nx[i] = '0;
      if (exp_bubble < CNT_MAX) exp_bubble++;
    end else if (STALL[0] == 1'b0) begin
      for (int a = 0; a < 32; a++) seen[a] = 1'b0;
      hilo_taken = 1'b0;
      // Walk youngest to oldest: first claimant of an address or of HI/LO wins.
      for (int i = LANES - 1; i >= 0; i--) begin
        nx[i].valid = MEM_VALID[i];
        nx[i].waddr = MEM_WADDR[i];
        nx[i].wdata = MEM_WDATA[i];
        nx[i].hi    = MEM_HI[i];
        nx[i].lo    = MEM_LO[i];
        nx[i].wen   = MEM_WEN[i] && MEM_VALID[i] && (MEM_WADDR[i] != 0) && !seen[MEM_WADDR[i]];
        if (nx[i].wen) seen[MEM_WADDR[i]] = 1'b1;
        nx[i].wen_hilo = MEM_WEN_HILO[i] && MEM_VALID[i] && !hilo_taken;
        if (nx[i].wen_hilo) hilo_taken = 1'b1;
      end
    end
    if (STALL[1] && exp_stall < CNT_MAX) exp_stall++;
    exp_q = nx;
  endtask

  task automatic check_all(input string tag);
    logic [LANES-1:0] ev, ew, eh;
    logic [LANES-1:0][DATA_W-1:0] ed, ehi, elo;
    logic [LANES-1:0][ADDR_W-1:0] ea;
    for (int i = 0; i < LANES; i++) begin
      ev[i] = exp_q[i].valid;  ew[i] = exp_q[i].wen;  eh[i] = exp_q[i].wen_hilo;
      ed[i] = exp_q[i].wdata;  ehi[i] = exp_q[i].hi;  elo[i] = exp_q[i].lo;
      ea[i] = exp_q[i].waddr;
    end
    chk({tag, ".valid"}, 64'(WB_VALID), 64'(ev));
    chk({tag, ".wen"},   64'(WB_WEN), 64'(ew));
    chk({tag, ".hilo"},  64'(WB_WEN_HILO), 64'(eh));
    chk({tag, ".waddr"}, 64'(WB_WADDR), 64'(ea));
    chk({tag, ".wdata"}, 64'(WB_WDATA), 64'(ed));
    chk({tag, ".hi"},    64'(WB_HI), 64'(ehi));
    chk({tag, ".lo"},    64'(WB_LO), 64'(elo));
`ifdef MEM_WB_PERF_CNT_EN
    chk({tag, ".stall_cnt"},  64'(STALL_CNT), 64'(exp_stall));
    chk({tag, ".bubble_cnt"}, 64'(BUBBLE_CNT), 64'(exp_bubble));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_inputs();
    MEM_VALID    = LANES'($urandom);
    MEM_WEN      = LANES'($urandom);
    MEM_WEN_HILO = LANES'($urandom);
    for (int i = 0; i < LANES; i++) begin
      MEM_WDATA[i] = $urandom;
      MEM_HI[i]    = $urandom;
      MEM_LO[i]    = $urandom;
      MEM_WADDR[i] = ADDR_W'($urandom_range(0, 3));
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic h);
    MEM_VALID[i] = v; MEM_WEN[i] = w; MEM_WADDR[i] = a; MEM_WDATA[i] = d;
    MEM_WEN_HILO[i] = h; MEM_HI[i] = d ^ 32'h5A5A_0000; MEM_LO[i] = ~d;
  endtask

  task automatic load_adv();
    set_lane(0, 1'b1, 1'b1, 5'd3, 32'h1111, 1'b0);
    set_lane(1, 1'b1, 1'b1, 5'd4, 32'h2222, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2 RST = 1'b0;
    model_reset();
    #1 check_all(tag);
    chk({tag, ".valid0"}, 64'(WB_VALID), 64'd0);
    #1 RST = 1'b1;
  endtask

  initial begin
    // Reset held with random activity on the inputs.
    RST = 1'b0; STALL = 2'b00; FLUSH = 1'b0;
    rand_inputs();
    model_reset();
    repeat (3) begin
      @(posedge CLK);
      rand_inputs();
      STALL = 2'($urandom);
      FLUSH = 1'($urandom);
    end
    #1;
    check_all("reset");
    chk("reset.wdata0", 64'(WB_WDATA), 64'd0);
    RST = 1'b1; STALL = 2'b00; FLUSH = 1'b0;

    // Two independent writes advance together.
    load_adv();
    step();
    check_all("adv");
    chk("adv.wen_lit",   64'(WB_WEN), 64'h3);
    chk("adv.addr_lit",  64'(WB_WADDR), 64'({5'd4, 5'd3}));
    chk("adv.data_lit",  64'(WB_WDATA), 64'h0000_2222_0000_1111);

    // Same-address collision and HI/LO collision: youngest wins.
    set_lane(0, 1'b1, 1'b1, 5'd7, 32'hAAAA, 1'b1);
    set_lane(1, 1'b1, 1'b1, 5'd7, 32'hBBBB, 1'b1);
    step();
    check_all("coll");
    chk("coll.wen_lit",  64'(WB_WEN), 64'h2);
    chk("coll.d1_lit",   64'(WB_WDATA[1]), 64'hBBBB);
    chk("coll.hilo_lit", 64'(WB_WEN_HILO), 64'h2);

    // $0 write and invalid lane.
    set_lane(0, 1'b1, 1'b1, 5'd0, 32'h0C0C, 1'b0);
    set_lane(1, 1'b0, 1'b1, 5'd9, 32'h0D0D, 1'b1);
    step();
    check_all("zero");
    chk("zero.wen_lit",   64'(WB_WEN), 64'h0);
    chk("zero.valid_lit", 64'(WB_VALID), 64'h1);
    chk("zero.hilo_lit",  64'(WB_WEN_HILO), 64'h0);
    chk("zero.a1_lit",    64'(WB_WADDR[1]), 64'd9);

    // MEM stop / WB go: bubble, then full stall holds.
    load_adv();
    step();
    check_all("bub.load");
    STALL = 2'b01;
    step();
    check_all("bub");
    chk("bub.valid_lit", 64'(WB_VALID), 64'h0);
    chk("bub.data_lit",  64'(WB_WDATA), 64'h0);
    STALL = 2'b11;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      step();
      check_all("hold");
      chk("hold.wen_lit", 64'(WB_WEN), 64'h0);
    end
`ifdef MEM_WB_PERF_CNT_EN
    chk("cnt.stall_lit",  64'(STALL_CNT), 64'd3);
    chk("cnt.bubble_lit", 64'(BUBBLE_CNT), 64'd1);
`endif

    // Full stall holds a live bundle.
    STALL = 2'b00;
    load_adv();
    step();
    STALL = 2'b11;
    rand_inputs();
    step();
    step();
    check_all("holdlive");
    chk("holdlive.d_lit", 64'(WB_WDATA), 64'h0000_2222_0000_1111);

    // FLUSH beats a full stall.
    FLUSH = 1'b1;
    step();
    check_all("flush");
    chk("flush.valid_lit", 64'(WB_VALID), 64'h0);
    FLUSH = 1'b0;
    STALL = 2'b00;

    // Reset dropped mid-cycle with live state.
    load_adv();
    step();
    async_reset("areset");

    // Randomized traffic; addresses narrowed to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      STALL = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      FLUSH = ($urandom_range(0, 9) == 0);
      step();
      check_all("rnd");
      if ($urandom_range(0, 49) == 0) async_reset("rnd.areset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
